// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_ctrl_pkg : forward encodings, FSM states, counter width, reg compare
// Revision: 1.0
// ----------------------------------------------------------------------------
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam int STALL_CNT_W = 16;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MEM_WAIT = 1'b1
   } mem_state_e;

   // $zero is hardwired, so a write to it can never create a dependency.
   function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
      return (dst != 5'd0) && (dst == src);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_forward_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// forward_unit : ALU and branch-compare operand forwarding selects
// Revision: 1.0
// ----------------------------------------------------------------------------
module forward_unit (
   input  logic       regWriteM,
   input  logic [4:0] writeRegM,
   input  logic       regWriteW,
   input  logic [4:0] writeRegW,
   input  logic [4:0] rsE,
   input  logic [4:0] rtE,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   output logic [1:0] fwdAE,
   output logic [1:0] fwdBE,
   output logic       fwdAD,
   output logic       fwdBD
);
   import hazard_ctrl_pkg::*;

   // MEM holds the younger result, so it takes priority over WB.
   always_comb begin
      fwdAE = FWD_RF;
      if (regWriteM && reg_match(writeRegM, rsE))
         fwdAE = FWD_M;
      else if (regWriteW && reg_match(writeRegW, rsE))
         fwdAE = FWD_W;

      fwdBE = FWD_RF;
      if (regWriteM && reg_match(writeRegM, rtE))
         fwdBE = FWD_M;
      else if (regWriteW && reg_match(writeRegW, rtE))
         fwdBE = FWD_W;

      fwdAD = regWriteM && reg_match(writeRegM, rsD);
      fwdBD = regWriteM && reg_match(writeRegM, rtD);
   end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_ctrl : pipeline stall/flush/forward control with data-memory wait FSM
// Revision: 1.0
// ----------------------------------------------------------------------------
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rsD,
   input  logic [4:0]  rtD,
   input  logic [4:0]  rsE,
   input  logic [4:0]  rtE,
   input  logic        regWriteE,
   input  logic        memToRegE,
   input  logic [4:0]  writeRegE,
   input  logic        regWriteM,
   input  logic        memToRegM,
   input  logic [4:0]  writeRegM,
   input  logic        regWriteW,
   input  logic [4:0]  writeRegW,
   input  logic        branchD,
   input  logic        branchTakenD,
   input  logic        dmemReqM,
   input  logic        dmemReady,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        stallM,
   output logic        flushD,
   output logic        flushE,
   output logic        flushW,
   output logic [1:0]  fwdAE,
   output logic [1:0]  fwdBE,
   output logic        fwdAD,
   output logic        fwdBD,
   output logic [15:0] stallCount
);
   import hazard_ctrl_pkg::*;

   mem_state_e             state_q, state_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   lw_stall, br_stall, mem_stall;
   logic [1:0]             fwd_ae_raw, fwd_be_raw;
   logic                   fwd_ad_raw, fwd_bd_raw;

   forward_unit u_forward_unit (
      .regWriteM (regWriteM),
      .writeRegM (writeRegM),
      .regWriteW (regWriteW),
      .writeRegW (writeRegW),
      .rsE       (rsE),
      .rtE       (rtE),
      .rsD       (rsD),
      .rtD       (rtD),
      .fwdAE     (fwd_ae_raw),
      .fwdBE     (fwd_be_raw),
      .fwdAD     (fwd_ad_raw),
      .fwdBD     (fwd_bd_raw)
   );

   always_comb begin
      lw_stall = memToRegE && (reg_match(writeRegE, rsD) || reg_match(writeRegE, rtD));
      br_stall = branchD &&
                 ((regWriteE && (reg_match(writeRegE, rsD) || reg_match(writeRegE, rtD))) ||
                  (memToRegM && (reg_match(writeRegM, rsD) || reg_match(writeRegM, rtD))));
   end

   // The ready cycle itself is not a stall: the pipeline advances as data arrives.
   always_comb begin
      state_d   = state_q;
      mem_stall = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dmemReqM && !dmemReady) begin
               state_d   = ST_MEM_WAIT;
               mem_stall = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (dmemReady)
               state_d = ST_IDLE;
            else
               mem_stall = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushW = 1'b0;
      fwdAE  = rst ? FWD_RF : fwd_ae_raw;
      fwdBE  = rst ? FWD_RF : fwd_be_raw;
      fwdAD  = !rst && fwd_ad_raw;
      fwdBD  = !rst && fwd_bd_raw;
      if (!rst) begin
         if (mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else if (lw_stall || br_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end else begin
            flushD = branchD && branchTakenD;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stallF && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stallCount = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
   logic        regWriteE, memToRegE, regWriteM, memToRegM, regWriteW;
   logic        branchD, branchTakenD, dmemReqM, dmemReady;
   logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
   logic [1:0]  fwdAE, fwdBE;
   logic        fwdAD, fwdBD;
   logic [15:0] stallCount;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt = 16'd0;

   // ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
   logic [6:0]  ctl;
   logic [5:0]  fwd;
   assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
   assign fwd = {fwdAE, fwdBE, fwdAD, fwdBD};

   localparam logic [6:0] CTL_NONE = 7'b0000000;
   localparam logic [6:0] CTL_HAZ  = 7'b1100010;
   localparam logic [6:0] CTL_MEM  = 7'b1111001;
   localparam logic [6:0] CTL_BRF  = 7'b0000100;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .regWriteE(regWriteE), .memToRegE(memToRegE), .writeRegE(writeRegE),
      .regWriteM(regWriteM), .memToRegM(memToRegM), .writeRegM(writeRegM),
      .regWriteW(regWriteW), .writeRegW(writeRegW),
      .branchD(branchD), .branchTakenD(branchTakenD),
      .dmemReqM(dmemReqM), .dmemReady(dmemReady),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushW(flushW),
      .fwdAE(fwdAE), .fwdBE(fwdBE), .fwdAD(fwdAD), .fwdBD(fwdBD),
      .stallCount(stallCount)
   );

   task automatic clear_inputs();
      rsD = 0; rtD = 0; rsE = 0; rtE = 0;
      regWriteE = 0; memToRegE = 0; writeRegE = 0;
      regWriteM = 0; memToRegM = 0; writeRegM = 0;
      regWriteW = 0; writeRegW = 0;
      branchD = 0; branchTakenD = 0; dmemReqM = 0; dmemReady = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      dmemReqM = 1; memToRegE = 1; writeRegE = 8; rtD = 8;
      regWriteM = 1; writeRegM = 5; rsE = 5; rsD = 5;
      branchD = 1; branchTakenD = 1;
      #2;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_NONE); end
      checks++; if (fwd !== 6'b0) begin errors++; $display("FAIL reset_fwd: got %b want %b", fwd, 6'b0); end
      next_cycle();
      checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h want %h", stallCount, 16'd0); end
      clear_inputs();
      rst = 1'b0;
      exp_cnt = 16'd0;
      #1;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL reset_release_ctl: got %b want %b", ctl, CTL_NONE); end
      next_cycle();
   endtask

   task automatic test_forward();
      clear_inputs();
      regWriteM = 1; writeRegM = 5; rsE = 5; regWriteW = 1; writeRegW = 5;
      #1;
      checks++; if (fwd !== 6'b10_00_0_0) begin errors++; $display("FAIL fwd_m_priority: got %b want %b", fwd, 6'b10_00_0_0); end
      regWriteM = 0; rtE = 5;
      #1;
      checks++; if (fwd !== 6'b01_01_0_0) begin errors++; $display("FAIL fwd_w_only: got %b want %b", fwd, 6'b01_01_0_0); end
      regWriteM = 1; writeRegM = 7; rsD = 7; rtD = 9; rsE = 9; rtE = 7; writeRegW = 9;
      #1;
      checks++; if (fwd !== 6'b01_10_1_0) begin errors++; $display("FAIL fwd_mixed: got %b want %b", fwd, 6'b01_10_1_0); end
      rsD = 9; rtD = 7;
      #1;
      checks++; if (fwd !== 6'b01_10_0_1) begin errors++; $display("FAIL fwd_bd: got %b want %b", fwd, 6'b01_10_0_1); end
      regWriteM = 0; regWriteW = 0;
      #1;
      checks++; if (fwd !== 6'b0) begin errors++; $display("FAIL fwd_no_write: got %b want %b", fwd, 6'b0); end
      clear_inputs();
      regWriteM = 1; regWriteW = 1;
      #1;
      checks++; if (fwd !== 6'b0) begin errors++; $display("FAIL fwd_reg0: got %b want %b", fwd, 6'b0); end
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL fwd_ctl_quiet: got %b want %b", ctl, CTL_NONE); end
      next_cycle();
   endtask

   task automatic test_lw_stall();
      clear_inputs();
      memToRegE = 1; writeRegE = 8; rtD = 8;
      #1;
      checks++; if (ctl !== CTL_HAZ) begin errors++; $display("FAIL lw_stall_rt: got %b want %b", ctl, CTL_HAZ); end
      next_cycle();
      exp_cnt++;
      memToRegE = 0;
      #1;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL lw_stall_release: got %b want %b", ctl, CTL_NONE); end
      checks++; if (stallCount !== exp_cnt) begin errors++; $display("FAIL lw_stall_cnt: got %h want %h", stallCount, exp_cnt); end
      memToRegE = 1; rsD = 8; rtD = 0;
      #1;
      checks++; if (ctl !== CTL_HAZ) begin errors++; $display("FAIL lw_stall_rs: got %b want %b", ctl, CTL_HAZ); end
      next_cycle();
      exp_cnt++;
      clear_inputs();
      #1;
      checks++; if (stallCount !== exp_cnt) begin errors++; $display("FAIL lw_stall_cnt2: got %h want %h", stallCount, exp_cnt); end
   endtask

   task automatic test_branch();
      clear_inputs();
      branchD = 1; branchTakenD = 1;
      #1;
      checks++; if (ctl !== CTL_BRF) begin errors++; $display("FAIL br_taken_flush: got %b want %b", ctl, CTL_BRF); end
      branchD = 0;
      #1;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL br_not_branch: got %b want %b", ctl, CTL_NONE); end
      branchD = 1; regWriteE = 1; writeRegE = 3; rsD = 3;
      #1;
      checks++; if (ctl !== CTL_HAZ) begin errors++; $display("FAIL br_stall_e: got %b want %b", ctl, CTL_HAZ); end
      regWriteE = 0; memToRegM = 1; writeRegM = 4; rtD = 4;
      #1;
      checks++; if (ctl !== CTL_HAZ) begin errors++; $display("FAIL br_stall_m: got %b want %b", ctl, CTL_HAZ); end
      branchD = 0;
      #1;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL br_stall_needs_branch: got %b want %b", ctl, CTL_NONE); end
      branchD = 1; memToRegM = 0; regWriteE = 1; writeRegE = 0; rsD = 0; rtD = 0;
      memToRegE = 1;
      #1;
      checks++; if (ctl !== CTL_BRF) begin errors++; $display("FAIL br_reg0_no_stall: got %b want %b", ctl, CTL_BRF); end
      next_cycle();
      clear_inputs();
      #1;
      checks++; if (stallCount !== exp_cnt) begin errors++; $display("FAIL br_cnt: got %h want %h", stallCount, exp_cnt); end
   endtask

   task automatic test_mem_stall();
      clear_inputs();
      dmemReqM = 1; dmemReady = 0;
      memToRegE = 1; writeRegE = 8; rtD = 8; branchD = 1; branchTakenD = 1;
      #1;
      checks++; if (ctl !== CTL_MEM) begin errors++; $display("FAIL mem_stall_c1: got %b want %b", ctl, CTL_MEM); end
      next_cycle();
      exp_cnt++;
      memToRegE = 0; branchD = 0; branchTakenD = 0;
      #1;
      checks++; if (ctl !== CTL_MEM) begin errors++; $display("FAIL mem_stall_c2: got %b want %b", ctl, CTL_MEM); end
      next_cycle();
      exp_cnt++;
      dmemReqM = 0;
      #1;
      checks++; if (ctl !== CTL_MEM) begin errors++; $display("FAIL mem_stall_c3: got %b want %b", ctl, CTL_MEM); end
      next_cycle();
      exp_cnt++;
      dmemReqM = 1; dmemReady = 1;
      #1;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL mem_ready_release: got %b want %b", ctl, CTL_NONE); end
      checks++; if (stallCount !== exp_cnt) begin errors++; $display("FAIL mem_cnt: got %h want %h", stallCount, exp_cnt); end
      next_cycle();
      dmemReqM = 0; dmemReady = 0;
      #1;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL mem_back_idle: got %b want %b", ctl, CTL_NONE); end
      dmemReqM = 1; dmemReady = 1;
      #1;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL mem_idle_ready: got %b want %b", ctl, CTL_NONE); end
      next_cycle();
      clear_inputs();
      #1;
      checks++; if (stallCount !== exp_cnt) begin errors++; $display("FAIL mem_cnt_after: got %h want %h", stallCount, exp_cnt); end
   endtask

   task automatic test_saturation();
      clear_inputs();
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      exp_cnt = 16'd0;
      dmemReqM = 1; dmemReady = 0;
      repeat (65534) @(posedge clk);
      #1;
      checks++; if (stallCount !== 16'hFFFE) begin errors++; $display("FAIL sat_near: got %h want %h", stallCount, 16'hFFFE); end
      next_cycle();
      checks++; if (stallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want %h", stallCount, 16'hFFFF); end
      checks++; if (ctl !== CTL_MEM) begin errors++; $display("FAIL sat_still_stall: got %b want %b", ctl, CTL_MEM); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (stallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want %h", stallCount, 16'hFFFF); end
   endtask

   task automatic test_reset_mid_wait();
      clear_inputs();
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      next_cycle();
      dmemReqM = 1; dmemReady = 0;
      next_cycle();
      dmemReqM = 0;
      regWriteM = 1; writeRegM = 6; rsE = 6;
      #1;
      checks++; if (ctl !== CTL_MEM) begin errors++; $display("FAIL rstw_in_wait: got %b want %b", ctl, CTL_MEM); end
      #2 rst = 1'b1;
      #1;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL rstw_ctl: got %b want %b", ctl, CTL_NONE); end
      checks++; if (fwd !== 6'b0) begin errors++; $display("FAIL rstw_fwd: got %b want %b", fwd, 6'b0); end
      checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL rstw_cnt: got %h want %h", stallCount, 16'd0); end
      #1 rst = 1'b0;
      #1;
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL rstw_idle: got %b want %b", ctl, CTL_NONE); end
      checks++; if (fwd !== 6'b10_00_0_0) begin errors++; $display("FAIL rstw_fwd_back: got %b want %b", fwd, 6'b10_00_0_0); end
      next_cycle();
      checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL rstw_idle2: got %b want %b", ctl, CTL_NONE); end
      checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL rstw_cnt2: got %h want %h", stallCount, 16'd0); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_lw_stall();
      test_branch();
      test_mem_stall();
      test_saturation();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
